// File: rtl/rgmii_tx_arbiter.sv
// Round-robin, frame-atomic arbiter feeding the RGMII MAC transmit AXI-stream.
// Enforces an inter-frame idle gap and truncates/aborts frames longer than MAX_LEN.
module rgmii_tx_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int MAX_LEN    = 1518,
  parameter int IFG_CYCLES = 4,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_PORTS-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]   s_axis_tlast,
  input  logic [NUM_PORTS-1:0]   s_axis_tuser,
  output logic [NUM_PORTS-1:0]   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic                   m_axis_tready,
  output logic                   grant_valid,
  output logic [2:0]             grant_idx,
  output logic                   frame_done,
  output logic                   frame_trunc
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, GAP} state_t;

  localparam state_t END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]       grant_idx_q, grant_idx_d;
  logic [2:0]       last_grant_q, last_grant_d;

  // Ports are padded to 8 so a 3-bit index can select any of them.
  logic [7:0]  valid_pad, last_pad, user_pad, ready_pad;
  logic [63:0] data_pad;
  logic [7:0]  sel_data;
  logic        sel_valid, sel_last, sel_user, at_max;
  logic [3:0]  cand;
  logic        found;
  logic [2:0]  winner;

  always_comb begin
    valid_pad = 8'(s_axis_tvalid);
    last_pad  = 8'(s_axis_tlast);
    user_pad  = 8'(s_axis_tuser);
    data_pad  = 64'(s_axis_tdata);
    sel_valid = valid_pad[grant_idx_q];
    sel_last  = last_pad[grant_idx_q];
    sel_user  = user_pad[grant_idx_q];
    sel_data  = data_pad[{grant_idx_q, 3'b000} +: 8];
    at_max    = (byte_cnt_q == LEN_W'(MAX_LEN - 1));
  end

  // Round-robin search starting just after the most recent winner.
  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    cand   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, last_grant_q} + 4'(k);
      if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
      if (!found && valid_pad[cand[2:0]]) begin
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

  always_comb begin
    m_axis_tdata  = sel_data;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    ready_pad     = '0;
    frame_done    = 1'b0;
    frame_trunc   = 1'b0;
    case (state_q)
      ACTIVE: begin
        m_axis_tvalid          = sel_valid;
        m_axis_tlast           = sel_last | at_max;
        m_axis_tuser           = sel_user | (at_max & ~sel_last);
        ready_pad[grant_idx_q] = m_axis_tready;
        frame_done             = sel_valid & m_axis_tready & (sel_last | at_max);
        frame_trunc            = sel_valid & m_axis_tready & at_max & ~sel_last;
      end
      DRAIN:   ready_pad[grant_idx_q] = 1'b1;
      default: ;
    endcase
    s_axis_tready = ready_pad[NUM_PORTS-1:0];
    grant_valid   = (state_q == ACTIVE) || (state_q == DRAIN);
    grant_idx     = grant_idx_q;
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_idx_d  = winner;
          last_grant_d = winner;
          byte_cnt_d   = '0;
          state_d      = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sel_valid && m_axis_tready) begin
          if (byte_cnt_q != LEN_W'(MAX_LEN)) byte_cnt_d = byte_cnt_q + LEN_W'(1);
          if (sel_last) begin
            state_d   = END_STATE;
            gap_cnt_d = '0;
          end else if (at_max) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Overlong tail is swallowed until the source finishes its frame.
        if (sel_valid && sel_last) begin
          state_d   = END_STATE;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= 3'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_arbiter.sv
// Bench for rgmii_tx_arbiter: frame queues per port feed a transaction-level model
// (round-robin owner, gap timer, truncation) that is compared against the DUT every cycle.
module tb_rgmii_tx_arbiter;

  localparam int NP  = 2;
  localparam int MAX = 72;
  localparam int IFG = 4;

  typedef struct {
    int len;
    int seed;
    bit abort;
    int pause_at;
    int pause_len;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [8*NP-1:0] s_axis_tdata = '0;
  logic [NP-1:0]   s_axis_tvalid = '0;
  logic [NP-1:0]   s_axis_tlast = '0;
  logic [NP-1:0]   s_axis_tuser = '0;
  logic [NP-1:0]   s_axis_tready;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic            m_axis_tready = 1'b1;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic            frame_done, frame_trunc;

  rgmii_tx_arbiter #(.NUM_PORTS(NP), .MAX_LEN(MAX), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .frame_done(frame_done), .frame_trunc(frame_trunc)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad = 0;

  frame_t fq[NP][$];
  int     src_idx[NP];
  int     pause_cnt[NP];
  bit     rdy_mode = 1'b0;

  // model state
  bit model_live = 1'b0;
  bit owned = 1'b0;
  bit drain = 1'b0;
  int mport = 0;
  int gidx = 0;
  int mlast = NP - 1;
  int mcnt = 0;
  int earliest = 0;
  int cyc = 0;
  int grant_hist[$];

  // DUT-side observations for the literal checks
  int out_lens[$];
  int end_users[$];
  int out_run = 0;
  int gap_run = 0;
  int last_gap = -1;
  bit ended = 1'b0;
  int dut_done_cnt = 0;
  int dut_trunc_cnt = 0;

  function automatic logic [7:0] byteOf(input frame_t f, input int i);
    return 8'((f.seed * 31 + i * 13 + 5) % 256);
  endfunction

  function automatic bit userOf(input frame_t f, input int i);
    return f.abort && (i == f.len - 1);
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int port, input int len, input int seed, input bit abort,
                               input int pause_at, input int pause_len);
    frame_t f;
    f.len = len;
    f.seed = seed;
    f.abort = abort;
    f.pause_at = pause_at;
    f.pause_len = pause_len;
    fq[port].push_back(f);
  endtask

  function automatic bit busy();
    bit b = owned;
    for (int p = 0; p < NP; p++) if (fq[p].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic waitDone(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 64'(busy()), 64'd0);
    repeat (IFG + 3) @(negedge clk);
  endtask

  task automatic applyReset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Source drivers: present queued frames, advance on handshakes seen at the prior negedge.
  always begin
    logic [NP-1:0] hs_cap;
    logic          rst_cap;
    frame_t        df;
    @(negedge clk);
    hs_cap  = s_axis_tvalid & s_axis_tready;
    rst_cap = rst;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (rst_cap) begin
        src_idx[p]   = 0;
        pause_cnt[p] = 0;
      end else if (hs_cap[p] && fq[p].size() > 0) begin
        if (src_idx[p] == fq[p][0].len - 1) begin
          void'(fq[p].pop_front());
          src_idx[p]   = 0;
          pause_cnt[p] = 0;
        end else begin
          src_idx[p]++;
        end
      end
      if (fq[p].size() > 0) begin
        df = fq[p][0];
        if (src_idx[p] == df.pause_at && pause_cnt[p] < df.pause_len) begin
          pause_cnt[p]++;
          s_axis_tvalid[p] = 1'b0;
        end else begin
          s_axis_tvalid[p] = 1'b1;
        end
        s_axis_tdata[8*p +: 8] = byteOf(df, src_idx[p]);
        s_axis_tlast[p]        = (src_idx[p] == df.len - 1);
        s_axis_tuser[p]        = userOf(df, src_idx[p]);
      end else begin
        s_axis_tvalid[p]       = 1'b0;
        s_axis_tlast[p]        = 1'b0;
        s_axis_tuser[p]        = 1'b0;
        s_axis_tdata[8*p +: 8] = 8'h00;
      end
    end
    m_axis_tready = rdy_mode ? ~m_axis_tready : 1'b1;
  end

  // Compare process: expected outputs from the frame-level model, then advance the model.
  always @(negedge clk) begin
    logic [NP-1:0] exp_rdy;
    logic          exp_mv, exp_done, exp_trunc, end_b, max_b, hs;
    frame_t        f;
    cyc++;
    if (model_live) begin
      exp_rdy = '0; exp_mv = 1'b0; exp_done = 1'b0; exp_trunc = 1'b0;
      checkOutput("grant_valid", 64'(grant_valid), 64'(owned));
      checkOutput("grant_idx", 64'(grant_idx), 64'(gidx));
      if (owned && drain) begin
        exp_rdy[mport] = 1'b1;
      end else if (owned && fq[mport].size() > 0) begin
        f = fq[mport][0];
        exp_rdy[mport] = m_axis_tready;
        exp_mv = s_axis_tvalid[mport];
        end_b = (mcnt == f.len - 1);
        max_b = (mcnt == MAX - 1);
        if (exp_mv) begin
          checkOutput("m_tdata", 64'(m_axis_tdata), 64'(byteOf(f, mcnt)));
          checkOutput("m_tlast", 64'(m_axis_tlast), 64'(end_b || max_b));
          checkOutput("m_tuser", 64'(m_axis_tuser), 64'(userOf(f, mcnt) || (max_b && !end_b)));
          if (m_axis_tready) begin
            exp_done  = end_b || max_b;
            exp_trunc = max_b && !end_b;
          end
        end
      end
      checkOutput("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
      checkOutput("m_tvalid", 64'(m_axis_tvalid), 64'(exp_mv));
      checkOutput("frame_done", 64'(frame_done), 64'(exp_done));
      checkOutput("frame_trunc", 64'(frame_trunc), 64'(exp_trunc));
    end

    if (frame_done) dut_done_cnt++;
    if (frame_trunc) dut_trunc_cnt++;
    if (ended) begin
      if (m_axis_tvalid) begin
        last_gap = gap_run;
        ended = 1'b0;
      end else begin
        gap_run++;
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      out_run++;
      if (m_axis_tlast) begin
        out_lens.push_back(out_run);
        end_users.push_back(int'(m_axis_tuser));
        out_run = 0;
        ended = 1'b1;
        gap_run = 0;
      end
    end

    if (rst) begin
      model_live = 1'b1;
      owned = 1'b0; drain = 1'b0; gidx = 0; mlast = NP - 1; mcnt = 0;
      earliest = cyc + 2;
      out_run = 0; ended = 1'b0;
    end else if (model_live) begin
      if (owned) begin
        hs = s_axis_tvalid[mport] && (drain || m_axis_tready);
        if (hs && !drain) begin
          f = fq[mport][0];
          if (mcnt == f.len - 1) begin
            owned = 1'b0;
            earliest = cyc + IFG + 2;
          end else if (mcnt == MAX - 1) begin
            drain = 1'b1;
          end
          mcnt++;
        end else if (hs && drain && s_axis_tlast[mport]) begin
          owned = 1'b0;
          drain = 1'b0;
          earliest = cyc + IFG + 2;
        end
      end else if (cyc + 1 >= earliest && s_axis_tvalid != '0) begin
        for (int k = 1; k <= NP; k++) begin
          if (!owned && s_axis_tvalid[(mlast + k) % NP]) begin
            owned = 1'b1;
            mport = (mlast + k) % NP;
          end
        end
        gidx = mport; mlast = mport; mcnt = 0; drain = 1'b0;
        grant_hist.push_back(mport);
      end
    end
  end

  initial begin
    int tr0, n;
    // reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_grant_valid", 64'(grant_valid), 64'd0);
    checkOutput("rst_grant_idx", 64'(grant_idx), 64'd0);
    checkOutput("rst_s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] single frame on port 0");
    grant_hist.delete(); out_lens.delete();
    applyStimulus(0, 64, 1, 1'b0, -1, 0);
    applyStimulus(0, 8, 2, 1'b0, -1, 0);
    waitDone(1000);
    checkOutput("single_len0", 64'(at(out_lens, 0)), 64'd64);
    checkOutput("single_len1", 64'(at(out_lens, 1)), 64'd8);
    checkOutput("single_grant", 64'(at(grant_hist, 0)), 64'd0);
    checkOutput("single_done_cnt", 64'(dut_done_cnt), 64'd2);
    checkOutput("single_gap", 64'(last_gap), 64'd5);

    $display("[TB] round robin");
    applyReset();
    grant_hist.delete(); out_lens.delete();
    applyStimulus(0, 60, 10, 1'b0, -1, 0);
    applyStimulus(0, 60, 11, 1'b0, -1, 0);
    applyStimulus(1, 60, 20, 1'b0, -1, 0);
    applyStimulus(1, 60, 21, 1'b0, -1, 0);
    waitDone(2000);
    checkOutput("rr_count", 64'(grant_hist.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_order", 64'(at(grant_hist, i)), 64'(i % 2));
      checkOutput("rr_len", 64'(at(out_lens, i)), 64'd60);
    end
    checkOutput("rr_gap", 64'(last_gap), 64'd5);

    $display("[TB] truncation");
    grant_hist.delete(); out_lens.delete(); end_users.delete();
    tr0 = dut_trunc_cnt;
    applyStimulus(1, 76, 30, 1'b0, -1, 0);
    n = 0;
    while (!owned && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("trunc_grant_wait", 64'(owned), 64'd1);
    applyStimulus(0, 8, 40, 1'b0, -1, 0);
    waitDone(1000);
    checkOutput("trunc_len", 64'(at(out_lens, 0)), 64'd72);
    checkOutput("trunc_user", 64'(at(end_users, 0)), 64'd1);
    checkOutput("trunc_pulses", 64'(dut_trunc_cnt - tr0), 64'd1);
    checkOutput("trunc_order0", 64'(at(grant_hist, 0)), 64'd1);
    checkOutput("trunc_order1", 64'(at(grant_hist, 1)), 64'd0);
    checkOutput("trunc_next_len", 64'(at(out_lens, 1)), 64'd8);

    $display("[TB] exact length and abort");
    grant_hist.delete(); out_lens.delete(); end_users.delete();
    tr0 = dut_trunc_cnt;
    applyStimulus(0, 72, 50, 1'b0, -1, 0);
    applyStimulus(1, 10, 60, 1'b1, -1, 0);
    waitDone(1000);
    checkOutput("exact_order0", 64'(at(grant_hist, 0)), 64'd1);
    checkOutput("abort_len", 64'(at(out_lens, 0)), 64'd10);
    checkOutput("abort_user", 64'(at(end_users, 0)), 64'd1);
    checkOutput("exact_len", 64'(at(out_lens, 1)), 64'd72);
    checkOutput("exact_user", 64'(at(end_users, 1)), 64'd0);
    checkOutput("exact_no_trunc", 64'(dut_trunc_cnt - tr0), 64'd0);

    $display("[TB] backpressure and source pause");
    grant_hist.delete(); out_lens.delete();
    rdy_mode = 1'b1;
    applyStimulus(0, 20, 70, 1'b0, 7, 3);
    waitDone(1000);
    rdy_mode = 1'b0;
    checkOutput("bp_len", 64'(at(out_lens, 0)), 64'd20);
    checkOutput("bp_grants", 64'(grant_hist.size()), 64'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 30, 80, 1'b0, -1, 0);
    n = 0;
    while (!(owned && mport == 1 && mcnt >= 10) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reach", 64'(mcnt >= 10), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    grant_hist.delete(); out_lens.delete();
    applyStimulus(0, 12, 90, 1'b0, -1, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_grant_valid", 64'(grant_valid), 64'd0);
    checkOutput("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    waitDone(1000);
    checkOutput("midrst_first", 64'(at(grant_hist, 0)), 64'd0);
    checkOutput("midrst_second", 64'(at(grant_hist, 1)), 64'd1);
    checkOutput("midrst_len0", 64'(at(out_lens, 0)), 64'd12);
    checkOutput("midrst_len1", 64'(at(out_lens, 1)), 64'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
